// File: rtl/bti_pkg.sv
// Shared BTI bus definitions: default widths and request/response payload types.
package bti_pkg;

  localparam int BTI_AW = 32;
  localparam int BTI_DW = 32;

  typedef struct packed {
    logic [BTI_AW-1:0]   addr;
    logic                wr;
    logic [BTI_DW-1:0]   wdata;
    logic [BTI_DW/8-1:0] strb;
  } bti_req_t;

  typedef struct packed {
    logic [BTI_DW-1:0] rdata;
    logic              ok;
  } bti_rsp_t;

endpackage

// File: rtl/bti_arb2_if.sv
// One BTI request/response link; master drives requests, slave drives responses.
interface bti_arb2_if #(
  parameter int AW = bti_pkg::BTI_AW,
  parameter int DW = bti_pkg::BTI_DW
);

  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_addr;
  logic          req_wr;
  logic [DW-1:0] req_wdata;
  logic [DW/8-1:0] req_strb;

  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_ok;

  modport master (
    output req_vld, req_addr, req_wr, req_wdata, req_strb, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_ok
  );

  modport slave (
    input  req_vld, req_addr, req_wr, req_wdata, req_strb, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata, rsp_ok
  );

endinterface

// File: rtl/bti_id_fifo.sv
// Small synchronous FIFO with combinational head read; a push is accepted
// when full only if a pop happens in the same cycle.
module bti_id_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          full, empty, do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/bti_arb2.sv
// Two-master to one-slave BTI arbiter: round-robin grant locked until handshake,
// responses steered back to the issuer through an in-order source-ID FIFO.
module bti_arb2
  import bti_pkg::*;
#(
  parameter int AW      = BTI_AW,
  parameter int DW      = BTI_DW,
  parameter int MAX_OUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  bti_arb2_if.slave  m0,
  bti_arb2_if.slave  m1,
  bti_arb2_if.master s,
  output logic       err
);

  localparam int CW = $clog2(MAX_OUT) + 1;

  logic [1:0]      m_req_vld, m_req_rdy, m_rsp_vld, m_rsp_rdy, m_req_wr;
  logic [AW-1:0]   m_req_addr  [2];
  logic [DW-1:0]   m_req_wdata [2];
  logic [DW/8-1:0] m_req_strb  [2];

  logic            prio_reg, prio_next;
  logic            lock_reg, lock_next;
  logic            lock_id_reg, lock_id_next;
  logic            err_reg, err_next;

  logic            grant, req_open, push, pop, head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  // Gather the two master links into indexable form.
  assign m_req_vld      = {m1.req_vld, m0.req_vld};
  assign m_req_wr       = {m1.req_wr, m0.req_wr};
  assign m_rsp_rdy      = {m1.rsp_rdy, m0.rsp_rdy};
  assign m_req_addr[0]  = m0.req_addr;
  assign m_req_addr[1]  = m1.req_addr;
  assign m_req_wdata[0] = m0.req_wdata;
  assign m_req_wdata[1] = m1.req_wdata;
  assign m_req_strb[0]  = m0.req_strb;
  assign m_req_strb[1]  = m1.req_strb;

  assign m0.req_rdy   = m_req_rdy[0];
  assign m1.req_rdy   = m_req_rdy[1];
  assign m0.rsp_vld   = m_rsp_vld[0];
  assign m1.rsp_vld   = m_rsp_vld[1];
  assign m0.rsp_rdata = s.rsp_rdata;
  assign m1.rsp_rdata = s.rsp_rdata;
  assign m0.rsp_ok    = s.rsp_ok;
  assign m1.rsp_ok    = s.rsp_ok;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(MAX_OUT));

  // Response side: steer to the oldest outstanding issuer; with nothing
  // outstanding the response is swallowed so the slave never stalls.
  assign pop       = ~rst & s.rsp_vld & ~fifo_empty & m_rsp_rdy[head];
  assign s.rsp_rdy = rst | fifo_empty | m_rsp_rdy[head];

  // A full FIFO still admits a request when a response retires this cycle,
  // which leaves a combinational path from the response handshake to s.req_vld.
  assign req_open = ~rst & ~(fifo_full & ~pop);

  always_comb begin
    grant = prio_reg;
    if (lock_reg) begin
      grant = lock_id_reg;
    end else if (!m_req_vld[prio_reg] && m_req_vld[~prio_reg]) begin
      grant = ~prio_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign m_req_rdy[gi] = req_open & s.req_rdy & (grant == 1'(gi));
      assign m_rsp_vld[gi] = ~rst & s.rsp_vld & ~fifo_empty & (head == 1'(gi));
    end
  endgenerate

  assign s.req_vld   = req_open & m_req_vld[grant];
  assign s.req_addr  = m_req_addr[grant];
  assign s.req_wr    = m_req_wr[grant];
  assign s.req_wdata = m_req_wdata[grant];
  assign s.req_strb  = m_req_strb[grant];

  assign push = s.req_vld & s.req_rdy;

  always_comb begin
    prio_next    = prio_reg;
    lock_next    = lock_reg;
    lock_id_next = lock_id_reg;
    err_next     = err_reg;
    if (push) begin
      prio_next = ~grant;
      lock_next = 1'b0;
    end else if (s.req_vld) begin
      lock_next    = 1'b1;
      lock_id_next = grant;
    end
    if (s.rsp_vld && fifo_empty) err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg    <= 1'b0;
      lock_reg    <= 1'b0;
      lock_id_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      prio_reg    <= prio_next;
      lock_reg    <= lock_next;
      lock_id_reg <= lock_id_next;
      err_reg     <= err_next;
    end
  end

  bti_id_fifo #(
    .W     (1),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk       (clk),
    .srst      (rst),
    .push      (push),
    .push_data (grant),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count)
  );

  assign err = err_reg;

endmodule

// File: tb/tb_bti_arb2.sv
// Directed bench for bti_arb2 with a queue-based reference model checked every cycle.
module tb_bti_arb2;

  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst;
  logic err;

  bti_arb2_if m0_bus ();
  bti_arb2_if m1_bus ();
  bti_arb2_if s_bus ();

  bti_arb2 #(.AW(32), .DW(32), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus),
    .err (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: outstanding issuers in order, favoured master, stall lock.
  int q[$];
  bit fav, locked, lock_id, m_err;
  bit e_push, e_pop, e_stray, e_svld, e_g;
  int e_head;

  always @(negedge clk) begin
    if (armed) begin
      logic [1:0] mv, mr;
      bit empty, can_take;
      logic [1:0] exp_rv;
      mv = {m1_bus.req_vld, m0_bus.req_vld};
      mr = {m1_bus.rsp_rdy, m0_bus.rsp_rdy};
      if (rst) begin
        e_push = 0; e_pop = 0; e_stray = 0; e_svld = 0;
        chk("rst_s_req_vld", s_bus.req_vld, 0);
        chk("rst_m_req_rdy", {m1_bus.req_rdy, m0_bus.req_rdy}, 0);
        chk("rst_m_rsp_vld", {m1_bus.rsp_vld, m0_bus.rsp_vld}, 0);
        chk("rst_s_rsp_rdy", s_bus.rsp_rdy, 1);
      end else begin
        empty    = (q.size() == 0);
        e_head   = empty ? 0 : q[0];
        e_pop    = s_bus.rsp_vld && !empty && mr[e_head];
        e_stray  = s_bus.rsp_vld && empty;
        can_take = (q.size() < MAX_OUT) || e_pop;
        if (locked)          e_g = lock_id;
        else if (mv[fav])    e_g = fav;
        else if (mv[!fav])   e_g = !fav;
        else                 e_g = fav;
        e_svld = mv[e_g] && can_take;
        e_push = e_svld && s_bus.req_rdy;
        chk("mdl_s_req_vld", s_bus.req_vld, e_svld);
        for (int i = 0; i < 2; i++) begin
          if (mv[i]) chk($sformatf("mdl_m%0d_req_rdy", i),
                         i ? m1_bus.req_rdy : m0_bus.req_rdy,
                         (i == int'(e_g)) && s_bus.req_rdy && can_take);
        end
        if (e_svld) begin
          chk("mdl_s_req_addr",  s_bus.req_addr,  e_g ? m1_bus.req_addr  : m0_bus.req_addr);
          chk("mdl_s_req_wr",    s_bus.req_wr,    e_g ? m1_bus.req_wr    : m0_bus.req_wr);
          chk("mdl_s_req_wdata", s_bus.req_wdata, e_g ? m1_bus.req_wdata : m0_bus.req_wdata);
          chk("mdl_s_req_strb",  s_bus.req_strb,  e_g ? m1_bus.req_strb  : m0_bus.req_strb);
        end
        exp_rv = (s_bus.rsp_vld && !empty) ? (2'b01 << e_head) : 2'b00;
        chk("mdl_m_rsp_vld", {m1_bus.rsp_vld, m0_bus.rsp_vld}, exp_rv);
        chk("mdl_s_rsp_rdy", s_bus.rsp_rdy, empty || mr[e_head]);
        if (s_bus.rsp_vld) begin
          chk("mdl_m0_rdata", m0_bus.rsp_rdata, s_bus.rsp_rdata);
          chk("mdl_m1_rdata", m1_bus.rsp_rdata, s_bus.rsp_rdata);
          chk("mdl_rsp_ok", {m1_bus.rsp_ok, m0_bus.rsp_ok}, {2{s_bus.rsp_ok}});
        end
      end
      chk("mdl_err", err, m_err);
    end
  end

  always @(posedge clk) begin
    if (armed) begin
      if (rst) begin
        q.delete();
        fav = 0; locked = 0; lock_id = 0; m_err = 0;
      end else begin
        if (e_pop) begin
          void'(q.pop_front());
          $display("rsp  -> m%0d rdata=%08h", e_head, s_bus.rsp_rdata);
        end
        if (e_stray) $display("rsp  dropped rdata=%08h", s_bus.rsp_rdata);
        if (e_push) begin
          q.push_back(int'(e_g));
          fav = !e_g;
          locked = 0;
          $display("req  m%0d addr=%08h wr=%0d", e_g, s_bus.req_addr, s_bus.req_wr);
        end else if (e_svld) begin
          locked = 1;
          lock_id = e_g;
        end
        if (e_stray) m_err = 1;
      end
    end
  end

  task automatic drv_m0(input logic v, input logic [31:0] a, input logic w);
    m0_bus.req_vld = v; m0_bus.req_addr = a; m0_bus.req_wr = w;
    m0_bus.req_wdata = a ^ 32'h5555_5555; m0_bus.req_strb = w ? 4'hF : 4'h0;
  endtask

  task automatic drv_m1(input logic v, input logic [31:0] a, input logic w);
    m1_bus.req_vld = v; m1_bus.req_addr = a; m1_bus.req_wr = w;
    m1_bus.req_wdata = a ^ 32'hAAAA_AAAA; m1_bus.req_strb = w ? 4'h3 : 4'h0;
  endtask

  task automatic drv_rsp(input logic v, input logic [31:0] d);
    s_bus.rsp_vld = v; s_bus.rsp_rdata = d; s_bus.rsp_ok = ~^d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_addr [4];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_addr[0] = 32'h200; exp_addr[1] = 32'h300;
    exp_addr[2] = 32'h204; exp_addr[3] = 32'h304;
    rst = 1'b1;
    drv_m0(0, 0, 0); drv_m1(0, 0, 0); drv_rsp(0, 0);
    m0_bus.rsp_rdy = 1; m1_bus.rsp_rdy = 1; s_bus.req_rdy = 1;
    @(posedge clk); #1 armed = 1'b1;
    @(negedge clk);
    chk("reset_m_req_rdy", {m1_bus.req_rdy, m0_bus.req_rdy}, 2'b00);
    chk("reset_s_req_vld", s_bus.req_vld, 0);
    chk("reset_s_rsp_rdy", s_bus.rsp_rdy, 1);
    chk("reset_err", err, 0);
    tick(); rst = 1'b0;

    // Single master read.
    drv_m0(1, 32'h100, 0);
    @(negedge clk);
    chk("single_s_req_addr", s_bus.req_addr, 32'h100);
    chk("single_m0_req_rdy", m0_bus.req_rdy, 1);
    tick(); drv_m0(0, 0, 0); drv_rsp(1, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_m0_rsp_vld", m0_bus.rsp_vld, 1);
    chk("single_m0_rdata", m0_bus.rsp_rdata, 32'hDEADBEEF);
    chk("single_m1_rsp_vld", m1_bus.rsp_vld, 0);
    chk("single_err", err, 0);
    tick(); drv_rsp(0, 0);
    rst = 1'b1; tick(); rst = 1'b0;

    // Contention: grants alternate 0,1,0,1 and fill the FIFO.
    for (int n = 0; n < 4; n++) begin
      drv_m0(1, 32'h200 + 32'(4 * ((n + 1) / 2)), 1);
      drv_m1(1, 32'h300 + 32'(4 * (n / 2)), 0);
      @(negedge clk);
      chk($sformatf("contend_addr%0d", n), s_bus.req_addr, exp_addr[n]);
      tick();
    end
    drv_m0(1, 32'h208, 1); drv_m1(0, 0, 0);
    @(negedge clk);
    chk("full_s_req_vld", s_bus.req_vld, 0);
    chk("full_m_req_rdy", {m1_bus.req_rdy, m0_bus.req_rdy}, 2'b00);
    tick(); drv_rsp(1, 32'hA0);
    @(negedge clk);
    chk("full_pop_m0_rsp", m0_bus.rsp_rdata, 32'hA0);
    chk("full_pop_accept", m0_bus.req_rdy, 1);
    chk("full_pop_addr", s_bus.req_addr, 32'h208);
    tick(); drv_m0(0, 0, 0); drv_rsp(0, 0); drv_m1(1, 32'h500, 0);
    @(negedge clk);
    chk("full_still4", s_bus.req_vld, 0);
    tick(); drv_rsp(1, 32'hA1);
    @(negedge clk);
    chk("full_m1_rsp_vld", m1_bus.rsp_vld, 1);
    chk("full_m1_accept", s_bus.req_addr, 32'h500);
    tick(); drv_m1(0, 0, 0);
    for (int k = 2; k < 6; k++) begin
      drv_rsp(1, 32'hA0 + 32'(k));
      @(negedge clk);
      chk($sformatf("order_rsp%0d", k),
          (k % 2) ? m1_bus.rsp_vld : m0_bus.rsp_vld, 1);
      tick();
    end
    drv_rsp(0, 0);

    // Response backpressure with head ID 1.
    drv_m1(1, 32'h600, 0);
    @(negedge clk);
    chk("bp_addr_m1", s_bus.req_addr, 32'h600);
    tick(); drv_m1(0, 0, 0); drv_m0(1, 32'h700, 0);
    @(negedge clk);
    chk("bp_addr_m0", s_bus.req_addr, 32'h700);
    tick(); drv_m0(0, 0, 0); m1_bus.rsp_rdy = 0; drv_rsp(1, 32'hB1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_s_rsp_rdy", s_bus.rsp_rdy, 0);
      chk("bp_m0_rsp_vld", m0_bus.rsp_vld, 0);
      tick();
    end
    m1_bus.rsp_rdy = 1;
    @(negedge clk);
    chk("bp_release", s_bus.rsp_rdy, 1);
    tick(); drv_rsp(1, 32'hB0);
    @(negedge clk);
    chk("bp_m0_after", m0_bus.rsp_vld, 1);
    tick(); drv_rsp(0, 0);

    // Lock: master 1 stalled by the slave while master 0 waits.
    drv_m1(1, 32'h800, 0); drv_m0(1, 32'h900, 1); s_bus.req_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lock_addr", s_bus.req_addr, 32'h800);
      chk("lock_m0_rdy", m0_bus.req_rdy, 0);
      tick();
    end
    s_bus.req_rdy = 1;
    @(negedge clk);
    chk("lock_hs_m1", m1_bus.req_rdy, 1);
    tick(); drv_m1(1, 32'h804, 0);
    @(negedge clk);
    chk("lock_then_m0", s_bus.req_addr, 32'h900);
    tick(); drv_m0(0, 0, 0);
    @(negedge clk);
    chk("lock_then_m1", s_bus.req_addr, 32'h804);
    tick(); drv_m1(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drv_rsp(1, 32'hC0 + 32'(k));
      @(negedge clk);
      chk($sformatf("lock_rsp%0d", k), (k % 2) ? m0_bus.rsp_vld : m1_bus.rsp_vld, 1);
      tick();
    end
    drv_rsp(0, 0);

    // Reset with two outstanding, then stray responses.
    drv_m0(1, 32'hA00, 0); drv_m1(1, 32'hB00, 0);
    tick(); drv_m0(0, 0, 0);
    tick(); drv_m1(0, 0, 0); rst = 1'b1;
    tick(); rst = 1'b0; drv_rsp(1, 32'hD0);
    @(negedge clk);
    chk("stray_s_rsp_rdy", s_bus.rsp_rdy, 1);
    chk("stray_m_rsp_vld", {m1_bus.rsp_vld, m0_bus.rsp_vld}, 2'b00);
    chk("stray_err_pre", err, 0);
    tick(); drv_rsp(1, 32'hD1);
    @(negedge clk);
    chk("stray_err_set", err, 1);
    tick(); drv_rsp(0, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("stray_err_held", err, 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("stray_err_clear", err, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bti_arb2.md
# bti_arb2

Two-master to one-slave arbiter for the BTI request/response bus. It lets the fetch path and the load/store path share a single TCM port: for example, a unified ITCM/DTCM behind the BIU, or a debug master sharing the DTCM. Requests are granted round-robin with grant locking until handshake. Each accepted request's source ID is recorded in an in-order FIFO so that slave responses are steered back to the issuing master.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_OUT, 4, maximum outstanding requests (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- m_req_vld[i]  in  1  master i (i=0,1) request valid
- m_req_rdy[i]  out  1  master i request ready
- m_req_addr[i]  in  AW  byte address
- m_req_wr[i]  in  1  1=write, 0=read
- m_req_wdata[i]  in  DW  write data
- m_req_strb[i]  in  DW/8  write byte strobes
- m_rsp_vld[i]  out  1  response valid to master i
- m_rsp_rdy[i]  in  1  master i response ready
- m_rsp_rdata[i]  out  DW  read data (broadcast to both masters; qualified by vld)
- m_rsp_ok[i]  out  1  response status
- s_req_vld / s_req_rdy / s_req_addr / s_req_wr / s_req_wdata / s_req_strb  out/in/out/out/out/out  as above  slave request
- s_rsp_vld / s_rsp_rdy / s_rsp_rdata / s_rsp_ok  in/out/in/in  as above  slave response
- err  out  1  sticky: slave response arrived with no outstanding entry

## Operation
- Handshake: a transfer occurs on vld&rdy. A master holds vld and its payload stable until rdy.
- Arbitration: round-robin over masters with a pending request. Register `prio` names the favoured master. After a request handshake from master g, `prio` becomes !g. Reset value of `prio` is 0.
- Lock: when s_req_vld=1 and s_req_rdy=0, register `lock` is set and the grant is frozen on `lock_id` until that handshake. No re-arbitration while locked.
- Request path is a combinational mux of the granted master: s_req_* = granted payload, s_req_vld = granted vld & !full, m_req_rdy[g] = s_req_rdy & !full, m_req_rdy[!g] = 0.
- ID FIFO, depth MAX_OUT, holds a 1-bit source ID per entry:
  - push on slave request handshake;
  - pop on master response handshake.
- `full` = (count == MAX_OUT). Push and pop in the same cycle are allowed when full; count is unchanged.
- Response steering: head = FIFO head ID. m_rsp_vld[head] = s_rsp_vld & !empty, m_rsp_vld[!head] = 0. s_rsp_rdy = m_rsp_rdy[head] | empty.
- With empty FIFO, s_rsp_vld is accepted (s_rsp_rdy=1), dropped, and sets err.
- err clears only on rst.

## Timing
- Zero added latency: request and response paths are combinational through the block. Only `prio`, `lock`, `lock_id`, FIFO pointers/count, and err are registered.
- Grant decision uses state registered in the previous cycle. A handshake in cycle N affects arbitration from cycle N+1.
- Both masters requesting continuously with slave always ready: grants alternate 0,1,0,1… one per cycle.
- rst in mid-operation: next cycle the FIFO is empty, count=0, prio=0, lock=0, err=0. In-flight responses arriving afterwards are dropped and set err. Masters must be reset together with the block.
- Reset values of outputs (rst high, inputs idle): m_req_rdy=0, m_rsp_vld=0, s_req_vld=0, s_rsp_rdy=1, err=0.

## Structure
- Shared package bti_pkg:
  - bti_req_t struct (addr, wr, wdata, strb);
  - bti_rsp_t struct (rdata, ok);
  - BTI_AW=32, BTI_DW=32.
- The MAX_OUT parameter is local to this block.
- One sub-module, bti_id_fifo: synchronous FIFO with width and depth parameters, count output, and simultaneous push/pop when full.
- Arbiter logic (prio/lock) stays in bti_arb2.

## Test plan
- Single master: master 0 reads 0x100, slave rsp rdata=0xDEADBEEF one cycle later → m_rsp_vld[0]=1 with 0xDEADBEEF; m_rsp_vld[1] stays 0; err=0.
- Contention: both masters assert vld every cycle, slave always ready → grants 0,1,0,1. Responses return in order, each to its issuer (rdata tagged 0xA0+n).
- Lock: master 1 granted, s_req_rdy=0 for 3 cycles while master 0 also requests → s_req_addr stays master 1's address throughout; master 0 is granted the cycle after the handshake.
- Full: MAX_OUT=4, slave accepts 4 requests and withholds responses → s_req_vld=0 and both m_req_rdy=0. First response pop in the same cycle as a new request → the request is accepted and count stays 4.
- Backpressure: m_rsp_rdy[1]=0 for 2 cycles with head ID=1 → s_rsp_rdy=0; master 0's later response is held behind it (in-order).
- Stray/reset: rst asserted with 2 outstanding, then 2 slave responses → both accepted and dropped, err=1 and held until the next rst.
